sfp_seq_ctrl: RTL and testbench

Sequencer for the SFP accumulate/ReLU stage. Once per layer it walks every output pixel `o` through all `kij` kernel positions: it clears the SFP, reads each per-kij psum from psum SRAM, and pulses `sfp_acc` aligned to the SRAM read data. It then writes the final ReLU'd SFP result to the output region. It sits between the top-level layer controller (`start`/`done`) and the SFP column array, the psum SRAM read port and the output SRAM write port.

---
 rtl/sfp_pkg.sv | 33 +++
 rtl/sfp_seq_ctrl_if.sv | 34 +++
 rtl/sfp_addr_gen.sv | 43 ++++
 rtl/sfp_seq_ctrl.sv | 86 ++++++++
 tb/tb_sfp_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sfp_pkg.sv
// Shared types and constants for the SFP accumulate/ReLU sequencer.
package sfp_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } sfp_state_e;

    localparam logic [STATE_W-1:0] S_IDLE  = IDLE;
    localparam logic [STATE_W-1:0] S_CLEAR = CLEAR;
    localparam logic [STATE_W-1:0] S_READ  = READ;
    localparam logic [STATE_W-1:0] S_DRAIN = DRAIN;
    localparam logic [STATE_W-1:0] S_WRITE = WRITE;
    localparam logic [STATE_W-1:0] S_DONE  = DONE;

    localparam int KIJ_DEFAULT  = 9;
    localparam int ONIJ_DEFAULT = 16;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int K_W = cnt_w(KIJ_DEFAULT);
    localparam int O_W = cnt_w(ONIJ_DEFAULT);

endpackage

// File: rtl/sfp_seq_ctrl_if.sv
// Bundle between the sequencer, the layer controller, the SFP array and the SRAM ports.
interface sfp_seq_ctrl_if
    import sfp_pkg::*;
#(
    parameter int addr_bw = 11
);
    // start is a level request honoured only while idle (bases sampled on that edge);
    // done pulses once per run; psum read data returns the cycle after psum_ren.
    logic               start;
    logic [addr_bw-1:0] psum_base;
    logic [addr_bw-1:0] out_base;
    logic               busy;
    logic               done;
    logic               psum_ren;
    logic [addr_bw-1:0] psum_addr;
    logic               sfp_reset;
    logic               sfp_acc;
    logic               out_wen;
    logic [addr_bw-1:0] out_addr;
    logic [STATE_W-1:0] state;

    modport master (
        input  start, psum_base, out_base,
        output busy, done, psum_ren, psum_addr, sfp_reset, sfp_acc,
               out_wen, out_addr, state
    );

    modport slave (
        output start, psum_base, out_base,
        input  busy, done, psum_ren, psum_addr, sfp_reset, sfp_acc,
               out_wen, out_addr, state
    );

endinterface

// File: rtl/sfp_addr_gen.sv
// Running-adder address generator: per-pixel plane pointer into psum SRAM and output pointer.
module sfp_addr_gen
    import sfp_pkg::*;
#(
    parameter int addr_bw = 11,
    parameter int onij    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               next_pixel,
    input  logic [addr_bw-1:0] psum_base,
    input  logic [addr_bw-1:0] out_base,
    output logic [addr_bw-1:0] plane_ptr,
    output logic [addr_bw-1:0] out_ptr
);

    localparam logic [addr_bw-1:0] STRIDE = addr_bw'(onij);
    localparam logic [addr_bw-1:0] ONE    = addr_bw'(1);

    logic [addr_bw-1:0] pix_base;

    // pix_base tracks psum_base + o; the plane pointer restarts from it for every pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_base  <= '0;
            plane_ptr <= '0;
            out_ptr   <= '0;
        end else if (load) begin
            pix_base  <= psum_base;
            plane_ptr <= psum_base;
            out_ptr   <= out_base;
        end else if (next_pixel) begin
            pix_base  <= pix_base + ONE;
            plane_ptr <= pix_base + ONE;
            out_ptr   <= out_ptr + ONE;
        end else if (step) begin
            plane_ptr <= plane_ptr + STRIDE;
        end
    end

endmodule

// File: rtl/sfp_seq_ctrl.sv
// Per-layer sequencer: for each output pixel clear the SFP, stream kij psums into it, write the result.
module sfp_seq_ctrl
    import sfp_pkg::*;
#(
    parameter int kij     = 9,
    parameter int onij    = 16,
    parameter int addr_bw = 11
) (
    input  logic           clk,
    input  logic           reset,
    sfp_seq_ctrl_if.master bus
);

    localparam int KW = cnt_w(kij);
    localparam int OW = cnt_w(onij);
    localparam logic [KW-1:0] K_LAST = KW'(kij - 1);
    localparam logic [OW-1:0] O_LAST = OW'(onij - 1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [KW-1:0]      k;
    logic [OW-1:0]      o;
    logic               acc_q;
    logic               accept;
    logic [addr_bw-1:0] plane_ptr;
    logic [addr_bw-1:0] out_ptr;

    assign accept = (state == S_IDLE) && bus.start;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_READ;
            S_READ:  if (k == K_LAST) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_WRITE;
            S_WRITE: state_nxt = (o == O_LAST) ? S_DONE : S_CLEAR;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // acc_q is psum_ren delayed one cycle so each strobe lines up with SRAM read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            k     <= '0;
            o     <= '0;
            acc_q <= 1'b0;
        end else begin
            state <= state_nxt;
            acc_q <= (state == S_READ);
            if (accept) o <= '0;
            if (state == S_CLEAR) k <= '0;
            if (state == S_READ) k <= k + KW'(1);
            if (state == S_WRITE && o != O_LAST) o <= o + OW'(1);
        end
    end

    sfp_addr_gen #(
        .addr_bw (addr_bw),
        .onij    (onij)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .step       (state == S_READ),
        .next_pixel (state == S_WRITE),
        .psum_base  (bus.psum_base),
        .out_base   (bus.out_base),
        .plane_ptr  (plane_ptr),
        .out_ptr    (out_ptr)
    );

    assign bus.psum_ren  = (state == S_READ);
    assign bus.psum_addr = bus.psum_ren ? plane_ptr : '0;
    assign bus.sfp_reset = (state == S_CLEAR);
    assign bus.sfp_acc   = acc_q;
    assign bus.out_wen   = (state == S_WRITE);
    assign bus.out_addr  = bus.out_wen ? out_ptr : '0;
    assign bus.busy      = (state == S_CLEAR) || (state == S_READ) ||
                           (state == S_DRAIN) || (state == S_WRITE);
    assign bus.done      = (state == S_DONE);
    assign bus.state     = state;

endmodule

// File: tb/tb_sfp_seq_ctrl.sv
// Bench for sfp_seq_ctrl with a psum SRAM and SFP accumulator/ReLU model attached.
module tb_sfp_seq_ctrl;
    import sfp_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sfp_seq_ctrl_if #(.addr_bw(11)) bus ();
    sfp_seq_ctrl_if #(.addr_bw(8))  bus8 ();

    sfp_seq_ctrl #(.kij(9), .onij(16), .addr_bw(11)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    sfp_seq_ctrl #(.kij(9), .onij(16), .addr_bw(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8.master)
    );

    typedef struct packed {
        logic        sfp_reset;
        logic        psum_ren;
        logic [10:0] psum_addr;
        logic        sfp_acc;
        logic        out_wen;
        logic [10:0] out_addr;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl [1:13];

    int n_total = 0;
    int n_pass  = 0;

    logic [26:0] rd_q[$];
    logic [42:0] wr_q[$];

    logic signed [15:0] psum_mem [0:2047];
    logic        [15:0] exp_data [0:15];
    logic signed [15:0] rdata;
    logic signed [31:0] sfp_sum;
    logic        [15:0] sfp_out;

    // psum SRAM (one-cycle read latency) feeding the SFP accumulator.
    always @(posedge clk) begin
        if (bus.psum_ren) rdata <= psum_mem[bus.psum_addr];
        if (bus.sfp_reset) sfp_sum <= 32'sd0;
        else if (bus.sfp_acc) sfp_sum <= sfp_sum + rdata;
    end
    assign sfp_out = (sfp_sum < 0) ? 16'd0 : sfp_sum[15:0];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic vec_t cur_vec();
        vec_t v;
        v.sfp_reset = bus.sfp_reset;
        v.psum_ren  = bus.psum_ren;
        v.psum_addr = bus.psum_addr;
        v.sfp_acc   = bus.sfp_acc;
        v.out_wen   = bus.out_wen;
        v.out_addr  = bus.out_addr;
        v.busy      = bus.busy;
        v.done      = bus.done;
        return v;
    endfunction

    task automatic reset_pulse();
        @(negedge clk);
        bus.start  = 1'b0;
        bus8.start = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_default(input int abort_at, input bit repulse, input bit hold);
        int last;
        int done_cnt;
        int acc_cnt;
        int busy_err;
        int post_err;
        logic [26:0] r;
        logic [42:0] w;
        vec_t v;
        done_cnt = 0;
        acc_cnt  = 0;
        busy_err = 0;
        post_err = 0;
        rd_q.delete();
        wr_q.delete();
        for (int o = 0; o < 16; o++) begin
            for (int k = 0; k < 9; k++) rd_q.push_back({16'(12 * o + 2 + k), 11'(k * 16 + o)});
            wr_q.push_back({16'(12 * o + 12), 11'(64 + o), exp_data[o]});
        end
        last = (abort_at != 0) ? abort_at + 10 : (hold ? 195 : 196);
        @(negedge clk);
        bus.psum_base = 11'd0;
        bus.out_base  = 11'd64;
        bus.start     = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= last; cyc++) begin
            @(negedge clk);
            v = cur_vec();
            if (cyc <= 13) check($sformatf("vec_c%0d", cyc), 64'(v), 64'(tbl[cyc]));
            if (abort_at != 0 && cyc > abort_at) begin
                if (cyc == abort_at + 1) check("reset_zero", 64'(v), 64'(0));
                else if (v != '0) post_err++;
            end else begin
                if (v.psum_ren) begin
                    r = (rd_q.size() != 0) ? rd_q.pop_front() : '1;
                    check($sformatf("rd_c%0d", cyc), 64'({16'(cyc), v.psum_addr}), 64'(r));
                end
                if (v.sfp_acc) acc_cnt++;
                if (v.out_wen) begin
                    w = (wr_q.size() != 0) ? wr_q.pop_front() : '1;
                    check($sformatf("wr_c%0d", cyc), 64'({16'(cyc), v.out_addr, sfp_out}), 64'(w));
                    check($sformatf("acc_pulses_c%0d", cyc), 64'(acc_cnt), 64'(9));
                    acc_cnt = 0;
                end
                if (v.done) begin
                    done_cnt++;
                    check("done_cycle", 64'(cyc), 64'(193));
                end
                if (v.busy !== ((cyc <= 192) || (hold && cyc >= 195))) busy_err++;
            end
            if (hold && cyc == 194) check("hold_idle", 64'({v.busy, v.done}), 64'(0));
            if (hold && cyc == 195) check("hold_clear", 64'({v.sfp_reset, v.busy}), 64'(3));
            bus.start = hold || (repulse && (cyc == 5 || cyc == 150));
            if (repulse) begin
                bus.psum_base = 11'd100;
                bus.out_base  = 11'd0;
            end
            if (abort_at != 0) reset = (cyc == abort_at);
        end
        if (abort_at != 0) begin
            check("post_reset_quiet", 64'(post_err), 64'(0));
        end else begin
            check("done_count", 64'(done_cnt), 64'(1));
            check("reads_left", 64'(rd_q.size()), 64'(0));
            check("writes_left", 64'(wr_q.size()), 64'(0));
            check("busy_window", 64'(busy_err), 64'(0));
        end
        reset_pulse();
    endtask

    task automatic run_wrap();
        logic [23:0] rd8_q[$];
        logic [23:0] wr8_q[$];
        logic [23:0] r;
        for (int o = 0; o < 2; o++) begin
            for (int k = 0; k < 9; k++) rd8_q.push_back({16'(12 * o + 2 + k), 8'((250 + o + k * 16) % 256)});
            wr8_q.push_back({16'(12 * o + 12), 8'((255 + o) % 256)});
        end
        @(negedge clk);
        bus8.psum_base = 8'd250;
        bus8.out_base  = 8'd255;
        bus8.start     = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 24; cyc++) begin
            @(negedge clk);
            bus8.start = 1'b0;
            if (bus8.psum_ren) begin
                r = (rd8_q.size() != 0) ? rd8_q.pop_front() : '1;
                check($sformatf("wrap_rd_c%0d", cyc), 64'({16'(cyc), bus8.psum_addr}), 64'(r));
            end
            if (bus8.out_wen) begin
                r = (wr8_q.size() != 0) ? wr8_q.pop_front() : '1;
                check($sformatf("wrap_wr_c%0d", cyc), 64'({16'(cyc), bus8.out_addr}), 64'(r));
            end
        end
        check("wrap_reads_left", 64'(rd8_q.size()), 64'(0));
        check("wrap_writes_left", 64'(wr8_q.size()), 64'(0));
        reset_pulse();
    endtask

    initial begin
        int val;
        int sum;
        bus.start      = 1'b0;
        bus.psum_base  = '0;
        bus.out_base   = '0;
        bus8.start     = 1'b0;
        bus8.psum_base = '0;
        bus8.out_base  = '0;

        for (int c = 1; c <= 13; c++) begin
            tbl[c] = '0;
            tbl[c].busy = 1'b1;
            tbl[c].sfp_reset = (c == 1) || (c == 13);
            if (c >= 2 && c <= 10) begin
                tbl[c].psum_ren  = 1'b1;
                tbl[c].psum_addr = 11'((c - 2) * 16);
            end
            tbl[c].sfp_acc = (c >= 3) && (c <= 11);
            if (c == 12) begin
                tbl[c].out_wen  = 1'b1;
                tbl[c].out_addr = 11'd64;
            end
        end

        for (int a = 0; a < 2048; a++) psum_mem[a] = 16'sd0;
        for (int o = 0; o < 16; o++) begin
            sum = 0;
            for (int k = 0; k < 9; k++) begin
                if (o == 3) val = (k < 5) ? -4 : 0;
                else if (o == 4) val = 5;
                else val = int'($urandom_range(0, 100)) - 50;
                psum_mem[k * 16 + o] = 16'(val);
                sum += val;
            end
            exp_data[o] = (sum < 0) ? 16'd0 : 16'(sum);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'(cur_vec()), 64'(0));
        check("reset_state", 64'(bus.state), 64'(S_IDLE));
        check("reset_outputs_w8", 64'({bus8.busy, bus8.done, bus8.psum_ren, bus8.psum_addr,
                                        bus8.sfp_reset, bus8.sfp_acc, bus8.out_wen, bus8.out_addr}),
              64'(0));
        reset = 1'b0;

        run_default(0, 1'b0, 1'b0);
        run_default(0, 1'b1, 1'b0);
        run_default(40, 1'b0, 1'b0);
        run_default(0, 1'b0, 1'b0);
        run_default(0, 1'b0, 1'b1);
        run_wrap();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
